chg_event_logger: RTL and testbench
===================================

Name: chg_event_logger

Overview:
- Sits directly downstream of the per-signal change-sensitive output stage.
- Samples its 6-bit level vector (o_0..o_5 packed, bit 0 = o_0) every clock and detects bits that changed since the previous sample.
- Each change is stored as a timestamped event record in a small FIFO and drained over a valid/ready interface.
- Events lost to a full FIFO are counted and flagged, so the consumer can tell an idle interval from a lossy one.

Parameters:
- WIDTH, 6: width of the monitored level vector.
- DEPTH, 8: FIFO entries. Must be a power of two, at least 2.
- TS_W, 16: width of the free-running timestamp counter.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 0, changes are tracked but not logged.
- in_vec  input  WIDTH  monitored levels.
- out_valid  output  1  FIFO head holds a record.
- out_ready  input  1  consumer accepts the head record this cycle.
- out_value  output  WIDTH  in_vec value sampled at the change.
- out_mask  output  WIDTH  bits that changed (in_vec XOR previous sample).
- out_ts  output  TS_W  timestamp of the change.
- out_lost  output  1  at least one record was dropped immediately before this record.
- drop_cnt  output  DROP_W  total dropped records, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears the FIFO, timestamp, drop_cnt, the sticky lost flag and the primed flag.
  - Reset outputs: out_valid=0, out_value=0, out_mask=0, out_ts=0, out_lost=0, drop_cnt=0.
  - Reset mid-operation discards queued records with no drain.
- Timestamp:
  - Increments by 1 every non-reset cycle and wraps from 2^TS_W-1 to 0.
  - A record carries the timestamp value of the cycle in which the change was sampled.
- Priming:
  - The first cycle after reset only loads the previous-sample register and produces no record, even if in_vec is nonzero.
  - After that cycle, primed=1.
- Change detection:
  - mask = in_vec ^ prev, computed each cycle.
  - prev <= in_vec every cycle, regardless of en.
  - Several bits changing in one cycle produce one record with several mask bits set.
- Push condition: primed && en && mask!=0.
- Pop condition: out_valid && out_ready.
- FIFO:
  - First-word fall-through; out_* show the head entry combinationally from storage.
  - A record pushed at edge N is visible with out_valid=1 after edge N (1-cycle latency).
  - Simultaneous push and pop when full: both are accepted, occupancy stays DEPTH, no drop.
  - Simultaneous push and pop when empty: the push is stored; the pop has no effect because out_valid was 0.
  - Push when full without a pop: the record is dropped, drop_cnt increments (saturating at 2^DROP_W-1), and the sticky lost flag is set.
- Lost flag:
  - The next successfully pushed record stores lost=1, then the sticky flag clears.
  - If a drop and an accepted push occur in the same cycle, that is impossible by construction, since a drop implies no push.
- out_value, out_mask, out_ts and out_lost are held stable while out_valid=1 and out_ready=0.
- Pointers are log2(DEPTH)+1 bits. Full and empty are derived by MSB compare.

Decomposition:
- Package chg_event_pkg holds:
  - The typedef chg_event_t, a packed struct {lost, ts, mask, value}.
  - Localparams for the default widths.
  - A helper function that computes the pointer width.
- Sub-module chg_event_fifo: generic synchronous first-word-fall-through FIFO over chg_event_t, with push, pop, full, empty and head.
- The top level holds priming, change detection, the timestamp, the drop counter and the lost flag.

Test Plan:
- Reset release with in_vec=6'h2A: no record on the priming cycle; out_valid stays 0; drop_cnt=0.
- After priming, drive in_vec 6'h00 -> 6'h05 at the cycle with ts=3: one record with value=05, mask=05, ts=3, lost=0; out_valid asserts 1 cycle later.
- Hold out_ready=0 and toggle bit 0 every cycle for 10 cycles with DEPTH=8: 8 records stored, drop_cnt=2. Drain one, then make the next change: it is stored with lost=1, and the following one with lost=0.
- FIFO full with a push and pop in the same cycle: occupancy stays 8, drop_cnt unchanged, and the popped head is the oldest record.
- en=0 while in_vec changes 00 -> 3F, then en=1 with no further change: no record. With en=1, the change 3F -> 3E produces mask=01.
- Timestamp wrap with TS_W=4: a change at the cycle after ts=15 records ts=0. A reset asserted with 3 queued records gives out_valid=0 and drop_cnt=0 on the next cycle.

Source files
------------

// File: rtl/chg_event_pkg.sv
// Shared types and sizing helpers for the change-event logger.
package chg_event_pkg;

  localparam int WIDTH_DEF  = 6;
  localparam int DEPTH_DEF  = 8;
  localparam int TS_W_DEF   = 16;
  localparam int DROP_W_DEF = 8;

  typedef struct packed {
    logic                  lost;
    logic [TS_W_DEF-1:0]   ts;
    logic [WIDTH_DEF-1:0]  mask;
    logic [WIDTH_DEF-1:0]  value;
  } chg_event_t;

  // One extra pointer bit distinguishes full from empty when the indices match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/chg_event_logger_if.sv
// Event record stream carried from the logger to its consumer.
interface chg_event_logger_if #(
  parameter int WIDTH = 6,
  parameter int TS_W  = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [WIDTH-1:0] out_mask;
  logic [TS_W-1:0]  out_ts;
  logic             out_lost;

  modport master (
    output out_valid, out_value, out_mask, out_ts, out_lost,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_value, out_mask, out_ts, out_lost,
    output out_ready
  );
endinterface

// File: rtl/chg_event_fifo.sv
// Synchronous first-word-fall-through FIFO; head is read straight from storage.
module chg_event_fifo
  import chg_event_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = chg_event_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/chg_event_logger.sv
// Detects bit changes on a level vector and queues timestamped event records.
module chg_event_logger
  import chg_event_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  in_vec,
  chg_event_logger_if.master ev,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef struct packed {
    logic              lost;
    logic [TS_W-1:0]   ts;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  value;
  } evt_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  logic [WIDTH-1:0] prev_p0;
  logic [WIDTH-1:0] mask;
  logic             primed;
  logic [TS_W-1:0]  ts;
  logic             lost_sticky;
  logic             push_req;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  evt_t             rec;
  evt_t             head;

  assign mask     = in_vec ^ prev_p0;
  assign push_req = primed && en && (|mask);
  assign pop      = ev.out_valid && ev.out_ready;
  assign drop     = push_req && fifo_full && !pop;

  assign rec = '{lost: lost_sticky, ts: ts, mask: mask, value: in_vec};

  // Previous sample tracks every cycle, even while logging is disabled.
  always_ff @(posedge clk) begin
    prev_p0 <= in_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed      <= 1'b0;
      ts          <= '0;
      drop_cnt    <= '0;
      lost_sticky <= 1'b0;
    end else begin
      primed <= 1'b1;
      ts     <= ts + 1'b1;
      if (drop) begin
        drop_cnt    <= sat_inc(drop_cnt);
        lost_sticky <= 1'b1;
      end else if (push_req) begin
        lost_sticky <= 1'b0;
      end
    end
  end

  chg_event_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Storage is not cleared on reset, so the head is masked to zero while empty.
  always_comb begin
    ev.out_valid = !fifo_empty;
    ev.out_value = '0;
    ev.out_mask  = '0;
    ev.out_ts    = '0;
    ev.out_lost  = 1'b0;
    if (!fifo_empty) begin
      ev.out_value = head.value;
      ev.out_mask  = head.mask;
      ev.out_ts    = head.ts;
      ev.out_lost  = head.lost;
    end
  end

endmodule

// File: tb/tb_chg_event_logger.sv
// Scoreboard bench for chg_event_logger: driver queues expected records, monitor checks pops.
module tb_chg_event_logger;

  localparam int WIDTH  = 6;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 4;
  localparam int DROP_W = 8;

  typedef struct packed {
    logic              lost;
    logic [TS_W-1:0]   ts;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  value;
  } rec_t;

  logic              clk;
  logic              rst;
  logic              en;
  logic [WIDTH-1:0]  in_vec;
  logic [DROP_W-1:0] drop_cnt;

  chg_event_logger_if #(.WIDTH(WIDTH), .TS_W(TS_W)) ev ();

  chg_event_logger #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .DROP_W(DROP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in_vec  (in_vec),
    .ev      (ev.master),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t             sb [$];
  logic [TS_W-1:0]  m_ts     = '0;
  logic [WIDTH-1:0] m_prev   = '0;
  logic             m_primed = 1'b0;
  logic             m_lost   = 1'b0;
  int               m_occ    = 0;
  int               m_drop   = 0;
  logic             started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; model state is committed at the edge.
  task automatic cyc(input logic r, input logic e, input logic [WIDTH-1:0] v, input logic rdy);
    logic             pop_m;
    logic             req;
    logic             acc;
    logic [WIDTH-1:0] mk;
    rec_t             rc;
    rst          = r;
    en           = e;
    in_vec       = v;
    ev.out_ready = rdy;
    pop_m = (m_occ != 0) && rdy;
    mk    = v ^ m_prev;
    req   = m_primed && e && (mk != '0);
    acc   = req && ((m_occ < DEPTH) || pop_m);
    rc    = '{lost: m_lost, ts: m_ts, mask: mk, value: v};
    @(posedge clk);
    if (r) begin
      sb.delete();
      m_occ    = 0;
      m_drop   = 0;
      m_lost   = 1'b0;
      m_primed = 1'b0;
      m_ts     = '0;
    end else begin
      if (acc) begin
        sb.push_back(rc);
        m_lost = 1'b0;
      end else if (req) begin
        m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        m_lost = 1'b1;
      end
      m_occ    = m_occ + int'(acc) - int'(pop_m);
      m_primed = 1'b1;
      m_ts     = m_ts + 1'b1;
    end
    m_prev  = v;
    started = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("valid_vs_model", 32'(ev.out_valid), 32'(m_occ != 0));
      chk("drop_cnt_vs_model", 32'(drop_cnt), 32'(m_drop));
      if (ev.out_valid && ev.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_record", 32'({ev.out_lost, ev.out_ts, ev.out_mask, ev.out_value}), 32'hFFFF_FFFF);
        end else begin
          chk("record", 32'({ev.out_lost, ev.out_ts, ev.out_mask, ev.out_value}), 32'(sb.pop_front()));
        end
      end
    end
  end

  logic [WIDTH-1:0] v;

  initial begin
    rst = 1'b1; en = 1'b0; in_vec = '0; ev.out_ready = 1'b0;
    cyc(1, 0, 6'h2A, 0);
    cyc(1, 0, 6'h2A, 0);
    chk("reset_valid", 32'(ev.out_valid), 0);
    chk("reset_fields", 32'({ev.out_lost, ev.out_ts, ev.out_mask, ev.out_value}), 0);
    chk("reset_drop", 32'(drop_cnt), 0);

    // Priming cycle (ts=0), then quiet cycles, then the first change at ts=3.
    cyc(0, 0, 6'h2A, 0);
    chk("prime_no_record", 32'(ev.out_valid), 0);
    cyc(0, 0, 6'h00, 0);
    cyc(0, 1, 6'h00, 0);
    chk("pre_change_valid", 32'(ev.out_valid), 0);
    cyc(0, 1, 6'h05, 0);
    chk("first_valid", 32'(ev.out_valid), 1);
    chk("first_value", 32'(ev.out_value), 32'h05);
    chk("first_mask", 32'(ev.out_mask), 32'h05);
    chk("first_ts", 32'(ev.out_ts), 3);
    chk("first_lost", 32'(ev.out_lost), 0);
    cyc(0, 1, 6'h05, 1);

    // Overflow: 10 toggles into an 8-deep FIFO with the consumer stalled.
    v = 6'h05;
    for (int i = 0; i < 10; i++) begin
      v = v ^ 6'h01;
      cyc(0, 1, v, 0);
    end
    chk("overflow_drop_cnt", 32'(drop_cnt), 2);
    chk("held_head_value", 32'(ev.out_value), 32'h04);
    chk("held_head_mask", 32'(ev.out_mask), 32'h01);
    cyc(0, 1, v, 1);
    v = v ^ 6'h01;
    cyc(0, 1, v, 0);
    // Full FIFO with simultaneous push and pop.
    v = v ^ 6'h01;
    cyc(0, 1, v, 1);
    chk("full_pushpop_drop", 32'(drop_cnt), 2);
    chk("full_pushpop_valid", 32'(ev.out_valid), 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, v, 1);

    // Enable gating: change while disabled is tracked but not logged.
    cyc(0, 1, 6'h00, 1);
    cyc(0, 1, 6'h00, 1);
    cyc(0, 0, 6'h3F, 1);
    cyc(0, 1, 6'h3F, 1);
    chk("en_off_no_record", 32'(ev.out_valid), 0);
    cyc(0, 1, 6'h3E, 1);
    chk("en_on_valid", 32'(ev.out_valid), 1);
    chk("en_on_mask", 32'(ev.out_mask), 32'h01);
    chk("en_on_value", 32'(ev.out_value), 32'h3E);
    cyc(0, 1, 6'h3E, 1);

    // Timestamp wrap: change in the cycle after ts=15.
    for (int k = 0; k < 16 && m_ts != 4'd15; k++) cyc(0, 1, 6'h3E, 1);
    cyc(0, 1, 6'h3E, 0);
    cyc(0, 1, 6'h3C, 0);
    chk("wrap_valid", 32'(ev.out_valid), 1);
    chk("wrap_ts", 32'(ev.out_ts), 0);
    cyc(0, 1, 6'h3D, 0);
    cyc(0, 1, 6'h3F, 0);

    // Reset with three queued records discards them.
    cyc(1, 1, 6'h00, 0);
    chk("midreset_valid", 32'(ev.out_valid), 0);
    chk("midreset_drop", 32'(drop_cnt), 0);
    chk("midreset_fields", 32'({ev.out_lost, ev.out_ts, ev.out_mask, ev.out_value}), 0);
    cyc(0, 1, 6'h00, 0);
    cyc(0, 1, 6'h11, 1);
    chk("post_reset_ts", 32'(ev.out_ts), 1);
    chk("post_reset_mask", 32'(ev.out_mask), 32'h11);
    cyc(0, 1, 6'h11, 1);
    cyc(0, 0, 6'h11, 0);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
